ahb_sram_subordinate: RTL and testbench

AHB subordinate that terminates transfers from `ahb_manager` (or any AHB-2 manager) into an internal flop-array memory. It sits on the responder side of the bus, behind the decoder and the HREADY/HRDATA mux. It supports programmable wait states, byte and halfword lanes, and two-cycle ERROR responses for illegal accesses. Its RETRY injection input drives the manager's rollback path during verification.

---
 rtl/ahb_sram_subordinate.sv | 182 ++++++++++++++++++
 tb/tb_ahb_sram_subordinate.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_subordinate.sv
// ahb_sram_subordinate
//   AHB subordinate that terminates transfers into an internal flop-array
//   memory. It supports programmable wait states, little-endian byte and
//   halfword lanes, and two-cycle ERROR/RETRY responses.
//
// Ports
//   i_hclk, i_hreset_n   clock (rising edge) / asynchronous active-low reset
//   i_hsel               decoder select
//   i_haddr, i_htrans,   address-phase controls (htrans: IDLE=0 BUSY=1
//   i_hsize, i_hburst,     NONSEQ=2 SEQ=3; hburst is informational only)
//   i_hwrite
//   i_hwdata             write data, valid in the data phase
//   i_hready             bus HREADY, qualifies the address phase
//   o_hready             HREADYOUT of this subordinate
//   o_hresp              OKAY=0 / ERROR=1 / RETRY=2
//   o_hrdata             read data, non-zero only in the completing cycle
//   i_wait               wait states for an OKAY transfer, sampled at accept
//   i_retry              forces RETRY on a NONSEQ transfer at accept
module ahb_sram_subordinate #(
  parameter int          DATA_WDT  = 32,
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  logic [1:0]          i_htrans,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic                i_hwrite,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic                o_hready,
  output logic [1:0]          o_hresp,
  output logic [DATA_WDT-1:0] o_hrdata,
  input  logic [3:0]          i_wait,
  input  logic                i_retry
);

  localparam int NBYTES = DATA_WDT / 8;
  localparam int LB     = $clog2(NBYTES);
  localparam int AW     = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS * NBYTES);

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HRESP_RETRY   = 2'b10;

  localparam logic [2:0] ST_READY = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_LAST  = 3'd2;
  localparam logic [2:0] ST_R1    = 3'd3;
  localparam logic [2:0] ST_R2    = 3'd4;

  logic [2:0]    state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [AW-1:0] idx_reg;
  logic [LB-1:0] lane_reg;
  logic [2:0]    size_reg;
  logic          write_reg;
  logic [1:0]    resp_reg;

  logic [DATA_WDT-1:0] mem_reg [MEM_WORDS];

  // Address decode. The offset is computed one bit wider so that an address
  // below BASE_ADDR wraps to a huge value and fails the range test.
  logic [32:0]   offset;
  logic [LB-1:0] align_mask;
  logic          out_of_range;
  logic          size_too_wide;
  logic          misaligned;
  logic          accept;
  logic [1:0]    resp_cls;
  logic          commit;
  logic [NBYTES-1:0] byte_en;
  logic          unused_bits;

  assign offset        = {1'b0, i_haddr} - {1'b0, BASE_ADDR};
  assign out_of_range  = (offset >= MEM_BYTES);
  assign size_too_wide = (i_hsize > 3'(LB));
  assign align_mask    = ~({LB{1'b1}} << i_hsize);
  assign misaligned    = ((i_haddr[LB-1:0] & align_mask) != '0);

  // The block only samples an address phase while its own HREADYOUT is high,
  // so nothing presented during WAIT or R1 can slip in.
  assign accept = i_hsel & i_hready & i_htrans[1] & o_hready;

  always_comb begin
    resp_cls = HRESP_OKAY;
    if (out_of_range || size_too_wide || misaligned) begin
      resp_cls = HRESP_ERROR;
    end else if (i_retry && (i_htrans == HTRANS_NONSEQ)) begin
      resp_cls = HRESP_RETRY;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = ST_LAST;
        end
      end
      ST_R1: begin
        state_next = ST_R2;
      end
      default: begin
        // READY, LAST and R2 all complete a data phase and may pipeline the
        // next accepted transfer straight in.
        state_next = ST_READY;
        cnt_next   = 4'd0;
        if (accept) begin
          if (resp_cls != HRESP_OKAY) begin
            state_next = ST_R1;
          end else if (i_wait != 4'd0) begin
            state_next = ST_WAIT;
            cnt_next   = i_wait;
          end else begin
            state_next = ST_LAST;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_reg <= ST_READY;
      cnt_reg   <= 4'd0;
      idx_reg   <= '0;
      lane_reg  <= '0;
      size_reg  <= 3'd0;
      write_reg <= 1'b0;
      resp_reg  <= HRESP_OKAY;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        idx_reg   <= offset[LB+AW-1:LB];
        lane_reg  <= i_haddr[LB-1:0];
        size_reg  <= i_hsize;
        write_reg <= i_hwrite;
        resp_reg  <= resp_cls;
      end
    end
  end

  // A byte lane is written when it falls in the same size-aligned group as
  // the transfer address.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign byte_en[gi] = ((LB'(gi) >> size_reg) == (lane_reg >> size_reg));
    end
  endgenerate

  // LAST is only ever entered with an OKAY response, so ERROR/RETRY
  // transfers can never reach the array.
  assign commit = (state_reg == ST_LAST) & write_reg & i_hreset_n;

  always_ff @(posedge i_hclk) begin
    if (commit) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (byte_en[b]) begin
          mem_reg[idx_reg][b*8 +: 8] <= i_hwdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_hready = (state_reg != ST_WAIT) && (state_reg != ST_R1);
  assign o_hresp  = ((state_reg == ST_R1) || (state_reg == ST_R2)) ? resp_reg : HRESP_OKAY;
  assign o_hrdata = (state_reg == ST_LAST) ? mem_reg[idx_reg] : '0;

  assign unused_bits = ^{i_hburst, offset[32:LB+AW], offset[LB-1:0]};

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
module tb_ahb_sram_subordinate;

  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [3:0]  wt;
  logic        retry;
  wire         hready_bus = hready_out;

  always #5 clk = ~clk;

  ahb_sram_subordinate #(
    .DATA_WDT (32),
    .MEM_WORDS(MEM_WORDS),
    .BASE_ADDR(32'h0)
  ) dut (
    .i_hclk    (clk),
    .i_hreset_n(rst_n),
    .i_hsel    (hsel),
    .i_haddr   (haddr),
    .i_htrans  (htrans),
    .i_hsize   (hsize),
    .i_hburst  (hburst),
    .i_hwrite  (hwrite),
    .i_hwdata  (hwdata),
    .i_hready  (hready_bus),
    .o_hready  (hready_out),
    .o_hresp   (hresp),
    .o_hrdata  (hrdata),
    .i_wait    (wt),
    .i_retry   (retry)
  );

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wt;
    logic        retry;
  } tr_t;

  tr_t         q[$];
  logic [31:0] mem_m [MEM_WORDS];
  int          checks = 0;
  int          errors = 0;
  int          dp_cycles;
  logic [31:0] last_rd;

  function automatic tr_t mk(logic [1:0] trans, logic [31:0] addr, logic [2:0] size,
                             logic wr, logic [31:0] wd, logic [3:0] w, logic rt);
    tr_t t;
    t.sel = 1'b1; t.trans = trans; t.addr = addr; t.size = size;
    t.write = wr; t.wdata = wd; t.wt = w; t.retry = rt;
    return t;
  endfunction

  function automatic tr_t mk_idle();
    return mk(2'b00, 32'h0, 3'd0, 1'b0, 32'h0, 4'd0, 1'b0);
  endfunction

  // 0 = not a transfer, 1 = OKAY, 2 = ERROR, 3 = RETRY
  function automatic int classify(tr_t t);
    if (!t.sel || (t.trans != 2'b10 && t.trans != 2'b11)) return 0;
    if (t.addr >= 32'(MEM_WORDS * 4)) return 2;
    if (t.size > 3'd2) return 2;
    if ((t.addr % (32'd1 << t.size)) != 0) return 2;
    if (t.retry && t.trans == 2'b10) return 3;
    return 1;
  endfunction

  // An aligned transfer of 2**size bytes covers the bytes starting at the
  // address offset within the word.
  task automatic apply_write(tr_t t);
    int first, n, w;
    first = int'(t.addr % 4);
    n     = 1 << t.size;
    w     = int'(t.addr / 4);
    for (int b = first; b < first + n; b++) begin
      mem_m[w][b*8 +: 8] = t.wdata[b*8 +: 8];
    end
  endtask

  task automatic drive_addr(tr_t t);
    hsel = t.sel; htrans = t.trans; haddr = t.addr; hsize = t.size;
    hwrite = t.write; wt = t.wt; retry = t.retry;
  endtask

  // Junk on the address bus while the subordinate stalls must be ignored.
  task automatic drive_random_addr();
    hsel = 1'($urandom); htrans = 2'($urandom); haddr = $urandom & 32'hFF;
    hsize = 3'($urandom_range(0, 3)); hwrite = 1'($urandom);
    wt = 4'($urandom); retry = 1'($urandom);
  endtask

  // Runs queue q as a pipelined sequence; each data phase is checked cycle
  // by cycle against the expected response length and read data.
  task automatic run_list(input string name);
    tr_t         cur, nxt;
    int          cls, len;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rd;
    logic        exp_rdy;
    dp_cycles = 0;
    if (q.size() != 0) begin
      drive_addr(q[0]);
      for (int k = 0; k < q.size(); k++) begin
        cur = q[k];
        nxt = (k + 1 < q.size()) ? q[k+1] : mk_idle();
        @(posedge clk); #1;
        hwdata   = cur.wdata;
        cls      = classify(cur);
        len      = (cls == 1) ? int'(cur.wt) + 1 : (cls >= 2) ? 2 : 1;
        exp_resp = (cls == 2) ? 2'b01 : (cls == 3) ? 2'b10 : 2'b00;
        for (int c = 0; c < len; c++) begin
          if (c == len - 1) drive_addr(nxt); else drive_random_addr();
          @(negedge clk);
          dp_cycles++;
          exp_rdy = (c == len - 1);
          exp_rd  = (cls == 1 && !cur.write && c == len - 1) ? mem_m[cur.addr / 4] : 32'h0;
          checks++;
          if (hready_out !== exp_rdy) begin
            errors++;
            $display("FAIL %s hready tr%0d cyc%0d: got %b want %b", name, k, c, hready_out, exp_rdy);
          end
          checks++;
          if (hresp !== exp_resp) begin
            errors++;
            $display("FAIL %s hresp tr%0d cyc%0d: got %0d want %0d", name, k, c, hresp, exp_resp);
          end
          if (!(cls == 1 && cur.write && c == len - 1)) begin
            checks++;
            if (hrdata !== exp_rd) begin
              errors++;
              $display("FAIL %s hrdata tr%0d cyc%0d: got %h want %h", name, k, c, hrdata, exp_rd);
            end
          end
          if (cls == 1 && !cur.write && c == len - 1) last_rd = hrdata;
          if (c < len - 1) begin @(posedge clk); #1; end
        end
        if (cls == 1 && cur.write) apply_write(cur);
        $display("%s tr%0d: %s addr=%h size=%0d cls=%0d cycles=%0d rdata=%h",
                 name, k, cur.write ? "WR" : "RD", cur.addr, cur.size, cls, len, hrdata);
      end
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_addr(mk_idle());
    hsel = 1'b0; hburst = 3'd0; hwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hready_out !== 1'b1) begin errors++; $display("FAIL reset hready: got %b want 1", hready_out); end
    checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL reset hresp: got %0d want 0", hresp); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset hrdata: got %h want 0", hrdata); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: hready=%b hresp=%0d hrdata=%h", hready_out, hresp, hrdata);
  endtask

  task automatic test_init();
    for (int i = 0; i < 64; i++) begin
      q.push_back(mk(2'b10, 32'(i * 4), 3'd2, 1'b1, $urandom, 4'd0, 1'b0));
    end
    run_list("init");
  endtask

  task automatic test_basic();
    q.push_back(mk(2'b10, 32'h10, 3'd2, 1'b1, 32'hDEADBEEF, 4'd0, 1'b0));
    q.push_back(mk(2'b10, 32'h10, 3'd2, 1'b0, 32'h0, 4'd0, 1'b0));
    run_list("basic");
    checks++;
    if (last_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic readback: got %h want deadbeef", last_rd); end
  endtask

  task automatic test_byte_lane();
    q.push_back(mk(2'b10, 32'h10, 3'd2, 1'b1, 32'h11223344, 4'd0, 1'b0));
    q.push_back(mk(2'b10, 32'h13, 3'd0, 1'b1, 32'hA5A5A5A5, 4'd0, 1'b0));
    q.push_back(mk(2'b10, 32'h10, 3'd2, 1'b0, 32'h0, 4'd0, 1'b0));
    q.push_back(mk(2'b10, 32'h22, 3'd1, 1'b1, 32'hBEEF0000, 4'd1, 1'b0));
    q.push_back(mk(2'b10, 32'h20, 3'd2, 1'b0, 32'h0, 4'd0, 1'b0));
    run_list("byte_lane");
    checks++;
    if (mem_m[4] !== 32'hA5223344) begin errors++; $display("FAIL byte_lane model: got %h want a5223344", mem_m[4]); end
  endtask

  task automatic test_burst_wait();
    hburst = 3'b011;
    q.push_back(mk(2'b10, 32'h0, 3'd2, 1'b0, 32'h0, 4'd3, 1'b0));
    q.push_back(mk(2'b11, 32'h4, 3'd2, 1'b0, 32'h0, 4'd3, 1'b0));
    q.push_back(mk(2'b11, 32'h8, 3'd2, 1'b0, 32'h0, 4'd3, 1'b0));
    q.push_back(mk(2'b11, 32'hC, 3'd2, 1'b0, 32'h0, 4'd3, 1'b0));
    run_list("burst_wait");
    hburst = 3'd0;
    checks++;
    if (dp_cycles != 16) begin errors++; $display("FAIL burst_wait cycles: got %0d want 16", dp_cycles); end
  endtask

  task automatic test_error();
    q.push_back(mk(2'b10, 32'(MEM_WORDS * 4), 3'd2, 1'b0, 32'h0, 4'd5, 1'b0));
    q.push_back(mk(2'b10, 32'h2, 3'd2, 1'b0, 32'h0, 4'd0, 1'b0));
    q.push_back(mk(2'b10, 32'h2, 3'd2, 1'b1, 32'hCAFEF00D, 4'd2, 1'b0));
    q.push_back(mk(2'b10, 32'h1, 3'd1, 1'b1, 32'hCAFEF00D, 4'd0, 1'b1));
    q.push_back(mk(2'b10, 32'h0, 3'd3, 1'b1, 32'hCAFEF00D, 4'd0, 1'b0));
    q.push_back(mk(2'b10, 32'hFFFFFFF0, 3'd2, 1'b1, 32'hCAFEF00D, 4'd0, 1'b0));
    q.push_back(mk(2'b10, 32'h0, 3'd2, 1'b0, 32'h0, 4'd0, 1'b0));
    run_list("error");
  endtask

  task automatic test_retry();
    q.push_back(mk(2'b10, 32'h40, 3'd2, 1'b1, 32'h12345678, 4'd4, 1'b1));
    q.push_back(mk(2'b10, 32'h40, 3'd2, 1'b0, 32'h0, 4'd0, 1'b0));
    run_list("retry");
    checks++;
    if (last_rd === 32'h12345678) begin errors++; $display("FAIL retry no_commit: got %h want old word", last_rd); end
    q.push_back(mk(2'b10, 32'h40, 3'd2, 1'b1, 32'h12345678, 4'd0, 1'b0));
    q.push_back(mk(2'b11, 32'h44, 3'd2, 1'b1, 32'h0BADCAFE, 4'd0, 1'b1));
    q.push_back(mk(2'b10, 32'h40, 3'd2, 1'b0, 32'h0, 4'd1, 1'b0));
    run_list("reissue");
    checks++;
    if (last_rd !== 32'h12345678) begin errors++; $display("FAIL reissue readback: got %h want 12345678", last_rd); end
  endtask

  task automatic test_random();
    tr_t t;
    int  sz, sel_kind;
    for (int i = 0; i < 200; i++) begin
      sz = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
      t  = mk(2'b10, 32'h0, 3'(sz), 1'($urandom), $urandom, 4'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0));
      t.addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 4) != 0) t.addr = t.addr & ~((32'd1 << sz) - 1);
      if ($urandom_range(0, 24) == 0) t.addr = 32'h1000 + ($urandom & 32'hFC);
      sel_kind = $urandom_range(0, 9);
      if (sel_kind == 0) t.sel = 1'b0;
      else if (sel_kind == 1) t.trans = 2'($urandom_range(0, 1));
      else if (sel_kind < 5) t.trans = 2'b11;
      q.push_back(t);
    end
    run_list("random");
  endtask

  task automatic test_reset_mid();
    logic [31:0] old;
    old = mem_m[8];
    drive_addr(mk(2'b10, 32'h20, 3'd2, 1'b1, 32'h0, 4'd5, 1'b0));
    @(posedge clk); #1;
    hwdata = ~old;
    drive_addr(mk_idle());
    #1;
    checks++; if (hready_out !== 1'b0) begin errors++; $display("FAIL reset_mid wait: got %b want 0", hready_out); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (hready_out !== 1'b1) begin errors++; $display("FAIL reset_mid hready: got %b want 1", hready_out); end
    checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL reset_mid hresp: got %0d want 0", hresp); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_mid hrdata: got %h want 0", hrdata); end
    $display("reset_mid: hready=%b hresp=%0d hrdata=%h", hready_out, hresp, hrdata);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    q.push_back(mk(2'b10, 32'h20, 3'd2, 1'b0, 32'h0, 4'd0, 1'b0));
    run_list("reset_mid_rd");
    checks++;
    if (last_rd !== old) begin errors++; $display("FAIL reset_mid word: got %h want %h", last_rd, old); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_byte_lane();
    test_burst_wait();
    test_error();
    test_retry();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
